pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch and next-PC controller for the single-issue core. It owns the program counter, runs the instruction-memory request/ready handshake, and waits for the datapath to resolve the instruction. It then selects the next PC: sequential +4, conditional branch, jal or jalr. It sits between the instruction memory and the decode/execute datapath, replacing free-running PC increments with a handshaked sequence that supports stalls and a misaligned-target trap.

## Interface
- PC_W, 10, PC and instruction-address width
- OFF_W, 21, width of the signed immediate offset
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  leave IDLE and begin fetching; ignored in all other states
- stall  in  1  hold the fetch request low while in FETCH
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address, always equal to pc
- imem_ready  in  1  memory accepts/returns the instruction this cycle
- instr_valid  out  1  one-cycle pulse: the instruction has been captured by the datapath
- ex_done  in  1  resolution inputs valid for the current instruction
- br_type  in  2  00 sequential, 01 conditional branch, 10 jal, 11 jalr
- br_cond  in  1  branch condition (zero-flag result), used only when br_type=01
- offset  in  OFF_W  signed immediate
- rs1_val  in  32  register-1 value for jalr
- pc  out  PC_W  current PC
- pc_plus4  out  PC_W  pc+4, the link value for jal/jalr
- busy  out  1  high in any state except IDLE and TRAP
- trap  out  1  sticky misaligned-target flag
- trap_pc  out  PC_W  offending target address

## Operation
- States: IDLE, FETCH, WAIT_EX, TRAP. Encoding is free; state is registered.
- IDLE: all requests low. start=1 moves to FETCH.
- FETCH: imem_req = !stall. A handshake occurs when imem_req && imem_ready. On a handshake, go to WAIT_EX. Otherwise stay in FETCH.
  - stall has priority: with stall=1, imem_ready is ignored.
- WAIT_EX: wait for ex_done. On ex_done, compute the target:
  - 00 → pc+4
  - 01 → pc+sext(offset) if br_cond, else pc+4
  - 10 → pc+sext(offset)
  - 11 → (rs1_val[PC_W-1:0]+sext(offset)) with bit0 cleared
- All sums are truncated to PC_W bits and wrap modulo 2^PC_W.
- If target[1:0]==00: pc <= target and go to FETCH. Otherwise: pc is unchanged, trap <= 1, trap_pc <= target, and go to TRAP.
- TRAP: terminal. imem_req=0 and all inputs are ignored. Exit is by reset only.
- ex_done outside WAIT_EX and imem_ready outside FETCH are ignored.
- pc_plus4 is combinational from pc and wraps (pc=0x3FC gives 0x000).

## Timing
- Reset (async, on reset=0): state=IDLE, pc=RESET_PC, trap=0, trap_pc=0, instr_valid=0, busy=0. imem_req=0 and imem_addr=RESET_PC.
- Reset asserted mid-operation aborts any fetch or execute in progress immediately, with no completion.
- start sampled high at edge N: FETCH from cycle N+1, so imem_req rises in cycle N+1 (if stall=0).
- imem_req depends combinationally on state and stall. All other outputs are registered or derived from registered values.
- Handshake at edge M: instr_valid=1 during cycle M+1 only.
- ex_done at edge K: the new pc is visible in cycle K+1, which is also a FETCH cycle.
- Minimum throughput is 2 cycles per instruction (ready and ex_done each accepted on their first cycle).
- ex_done is accepted in the same cycle that instr_valid is high.

## Test plan
- Reset then start, imem_ready tied 1, ex_done tied 1, br_type=00: pc sequence 0,4,8,12 with one new PC every 2 cycles; instr_valid pulses each time.
- Conditional branch at pc=0x010, offset=-8:
  - br_cond=1 → next pc 0x008
  - br_cond=0 → next pc 0x014
- jalr with rs1_val=0x123, offset=+5: target 0x128, pc=0x128, pc_plus4 at the jalr PC = pc+4. jal at pc=0x3FC, offset=+8: pc wraps to 0x004.
- stall=1 for 3 cycles in FETCH with imem_ready=1: imem_req=0 and no instr_valid. The handshake completes in the first cycle after stall drops.
- Misaligned target (jal with offset=+6 at pc=0x000): trap=1, trap_pc=0x006, pc stays 0x000, busy=0. Later start, imem_ready and ex_done have no effect until reset.
- Reset asserted mid-WAIT_EX with ex_done=1 on the same edge: pc=RESET_PC, state IDLE, no PC update is taken.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch / next-PC controller: handshakes each fetch with instruction memory,
// waits for the datapath to resolve it, then steps, branches or traps.
module pc_sequencer #(
  parameter int              PC_W     = 10,
  parameter int              OFF_W    = 21,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stall_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_ready_i,
  output logic             instr_valid_o,
  input  logic             ex_done_i,
  input  logic [1:0]       br_type_i,
  input  logic             br_cond_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [31:0]      rs1_val_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus4_o,
  output logic             busy_o,
  output logic             trap_o,
  output logic [PC_W-1:0]  trap_pc_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT_EX = 2'd2,
    TRAP    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] trap_pc_q, trap_pc_d;
  logic            trap_q, trap_d;
  logic            instr_valid_q, instr_valid_d;

  logic [PC_W+OFF_W-1:0] off_wide;
  logic [PC_W-1:0]       off_ext;
  logic [PC_W-1:0]       target;
  logic                  unused_bits;

  // Sign-extend past PC_W, then keep the low bits: arithmetic wraps mod 2^PC_W.
  assign off_wide    = {{PC_W{offset_i[OFF_W-1]}}, offset_i};
  assign off_ext     = off_wide[PC_W-1:0];
  assign unused_bits = ^{off_wide[PC_W+OFF_W-1:PC_W], rs1_val_i[31:PC_W]};

  assign pc_plus4_o    = pc_q + PC_W'(4);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign trap_o        = trap_q;
  assign trap_pc_o     = trap_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign busy_o        = (state_q == FETCH) || (state_q == WAIT_EX);

  always_comb begin
    target = pc_plus4_o;
    case (br_type_i)
      2'b01:   target = br_cond_i ? (pc_q + off_ext) : pc_plus4_o;
      2'b10:   target = pc_q + off_ext;
      2'b11:   target = (rs1_val_i[PC_W-1:0] + off_ext) & ~PC_W'(1);
      default: target = pc_plus4_o;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    trap_d        = trap_q;
    trap_pc_d     = trap_pc_q;
    instr_valid_d = 1'b0;
    imem_req_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        imem_req_o = !stall_i;
        if (!stall_i && imem_ready_i) begin
          state_d       = WAIT_EX;
          instr_valid_d = 1'b1;
        end
      end
      WAIT_EX: begin
        if (ex_done_i) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = FETCH;
          end else begin
            trap_d    = 1'b1;
            trap_pc_d = target;
            state_d   = TRAP;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_q        <= trap_d;
      trap_pc_q     <= trap_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a transaction-level PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, imem_req, imem_ready, instr_valid, ex_done;
  logic [9:0]  imem_addr, pc, pc_plus4, trap_pc;
  logic [1:0]  br_type;
  logic        br_cond, busy, trap;
  logic [20:0] offset;
  logic [31:0] rs1_val;

  int tests = 0;
  int fails = 0;
  int m_pc  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(10), .OFF_W(21), .RESET_PC(10'h000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
    .instr_valid_o(instr_valid), .ex_done_i(ex_done), .br_type_i(br_type),
    .br_cond_i(br_cond), .offset_i(offset), .rs1_val_i(rs1_val),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .busy_o(busy), .trap_o(trap), .trap_pc_o(trap_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap10(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  // One full instruction starting in a FETCH cycle: stalls, ready wait, execute wait, resolve.
  task automatic run_instr(input logic [1:0] bt, input logic cond, input logic [20:0] off,
                           input logic [31:0] rs1, input int n_stall, input int n_rdy, input int n_ex);
    int o, tgt;
    o = int'(off);
    if (off[20]) o = o - (1 << 21);
    case (bt)
      2'd0:    tgt = m_pc + 4;
      2'd1:    tgt = cond ? m_pc + o : m_pc + 4;
      2'd2:    tgt = m_pc + o;
      default: tgt = int'(rs1 & 32'h3FF) + o;
    endcase
    tgt = wrap10(tgt);
    if (bt == 2'd3) tgt = tgt & ~1;
    for (int i = 0; i < n_stall; i++) begin
      stall = 1'b1; imem_ready = 1'b1; #1;
      chk("stall_req", imem_req, 0);
      chk("stall_iv", instr_valid, 0);
      tick();
    end
    for (int i = 0; i < n_rdy; i++) begin
      stall = 1'b0; imem_ready = 1'b0; #1;
      chk("wait_req", imem_req, 1);
      tick();
    end
    stall = 1'b0; imem_ready = 1'b1; #1;
    chk("hs_req", imem_req, 1);
    chk("hs_addr", imem_addr, m_pc);
    tick();
    imem_ready = 1'b0;
    chk("iv_pulse", instr_valid, 1);
    chk("link", pc_plus4, wrap10(m_pc + 4));
    chk("wait_ex_req", imem_req, 0);
    for (int i = 0; i < n_ex; i++) begin
      ex_done = 1'b0;
      tick();
      chk("iv_once", instr_valid, 0);
    end
    br_type = bt; br_cond = cond; offset = off; rs1_val = rs1; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    if ((tgt & 3) == 0) begin
      m_pc = tgt;
      chk("next_pc", pc, m_pc);
      chk("next_busy", busy, 1);
      chk("next_req", imem_req, 1);
    end else begin
      chk("trap", trap, 1);
      chk("trap_pc", trap_pc, tgt);
      chk("trap_keep_pc", pc, m_pc);
      chk("trap_busy", busy, 0);
    end
    $display("[TB] instr bt=%0d cond=%0d off=%0h rs1=%0h -> pc=%0h trap=%0d", bt, cond, off, rs1, pc, trap);
  endtask

  task automatic do_reset_start();
    rst_n = 1'b0; #1;
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trap", trap, 0);
    chk("rst_trap_pc", trap_pc, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    tick();
    rst_n = 1'b1;
    m_pc  = 0;
    tick();
    chk("idle_req", imem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_req", imem_req, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; imem_ready = 0; ex_done = 0;
    br_type = 0; br_cond = 0; offset = 0; rs1_val = 0;
    do_reset_start();

    // Sequential at full rate: 0 -> 4 -> 8 -> 12 -> 16
    for (int i = 0; i < 4; i++) run_instr(2'd0, 1'b0, 21'd0, 32'd0, 0, 0, 0);
    // Conditional branch at 0x010 with offset -8, taken then not taken
    run_instr(2'd1, 1'b1, -21'sd8, 32'd0, 0, 0, 0);
    run_instr(2'd0, 1'b0, 21'd0, 32'd0, 0, 0, 0);
    run_instr(2'd0, 1'b0, 21'd0, 32'd0, 0, 0, 0);
    run_instr(2'd1, 1'b0, -21'sd8, 32'd0, 0, 0, 0);
    // jalr 0x123+5 -> 0x128, then jal to 0x3FC and wrap to 0x004
    run_instr(2'd3, 1'b0, 21'd5, 32'h123, 0, 0, 0);
    run_instr(2'd2, 1'b0, 21'h2D4, 32'd0, 0, 0, 0);
    run_instr(2'd2, 1'b0, 21'd8, 32'd0, 0, 0, 0);
    // Three stall cycles with ready held high
    run_instr(2'd0, 1'b0, 21'd0, 32'd0, 3, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [20:0] roff;
      logic [31:0] rrs1;
      roff = 21'($urandom_range(0, 511)) << 2;
      if ($urandom_range(0, 1) == 1) roff = -roff;
      rrs1 = ($urandom() & ~32'h3) | 32'($urandom_range(0, 1));
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), roff, rrs1,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset lands on the same edge as ex_done: no PC update
    stall = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    br_type = 2'd2; offset = 21'd8; ex_done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pc_async", pc, 0);
    chk("abort_busy_async", busy, 0);
    tick();
    chk("abort_pc", pc, 0);
    chk("abort_iv", instr_valid, 0);
    rst_n = 1'b1; ex_done = 1'b0;
    tick();
    chk("abort_idle_req", imem_req, 0);
    chk("abort_idle_busy", busy, 0);

    // Misaligned jal from 0x000 locks into trap until reset
    do_reset_start();
    run_instr(2'd2, 1'b0, 21'd6, 32'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; stall = 1'b0; imem_ready = 1'b1; ex_done = 1'b1;
      tick();
      chk("trap_hold", trap, 1);
      chk("trap_hold_pc", pc, 0);
      chk("trap_hold_tpc", trap_pc, 6);
      chk("trap_hold_req", imem_req, 0);
      chk("trap_hold_iv", instr_valid, 0);
      chk("trap_hold_busy", busy, 0);
    end
    start = 1'b0; imem_ready = 1'b0; ex_done = 1'b0;
    do_reset_start();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
